// File: rtl/sli_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sli_pkg
// Description : Shared constants for the structured-light sequencer:
//               FSM state encoding, pattern index ranges and default timing.
// Revision    : 1.0 - initial release
// ============================================================================
package sli_pkg;

  // Sequencer state encoding (visible on state_dbg)
  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_WAIT_RDY = 2'd1;
  localparam logic [1:0] ST_ARM      = 2'd2;
  localparam logic [1:0] ST_EXPOSE   = 2'd3;

  // Pattern space: 3 spatial frequencies x 8 phase frames
  localparam int NUM_FRA = 8;
  localparam int NUM_FRQ = 3;

  // Default timing
  localparam int unsigned DEF_EXP_CYCLES     = 32'h0008_0000;
  localparam logic [7:0]  DEF_TIMEOUT_FRAMES = 8'd240;

endpackage : sli_pkg
`default_nettype wire

// File: rtl/sli_seq_ctrl_sync_rise.sv
`default_nettype none
// ============================================================================
// Module      : sync_rise
// Description : Two-flop synchronizer for an asynchronous level, followed by
//               a registered rising-edge detector. rise_o is a one-cycle
//               pulse three clocks after the input goes high.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_rise (
  input  logic clk,
  input  logic rstn,
  input  logic d_i,
  output logic rise_o
);

  // [0],[1] form the synchronizer, [2] is the delayed copy for edge detect
  logic [2:0] sync_q;
  logic       rise_q;

  // Synchronize the input and register a single-cycle pulse on its rise
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync_q <= 3'b000;
      rise_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[1:0], d_i};
      rise_q <= sync_q[1] & ~sync_q[2];
    end
  end

  assign rise_o = rise_q;

endmodule : sync_rise
`default_nettype wire

// File: rtl/sli_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : sli_seq_ctrl
// Description : Structured-light pattern sequencer. Steps through 3 spatial
//               frequencies x 8 phase frames, one step per camera-ready
//               handshake aligned to vsync, and fires an exposure trigger of
//               fixed length on the frame after each step.
// Revision    : 1.0 - initial release
// ============================================================================
module sli_seq_ctrl
  import sli_pkg::*;
#(
  parameter int unsigned EXP_CYCLES     = DEF_EXP_CYCLES,
  parameter logic [7:0]  TIMEOUT_FRAMES = DEF_TIMEOUT_FRAMES
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       mode,
  input  logic       vsync,
  input  logic       rdy,
  output logic [1:0] frq,
  output logic [2:0] fra,
  output logic       hold,
  output logic       trig,
  output logic       f_frm,
  output logic       seq_done,
  output logic       rdy_timeout,
  output logic [1:0] state_dbg
);

  localparam int              EXP_CW   = (EXP_CYCLES > 1) ? $clog2(EXP_CYCLES) : 1;
  localparam logic [EXP_CW-1:0] EXP_LAST = EXP_CW'(EXP_CYCLES - 1);
  localparam logic [2:0]      FRA_LAST = 3'(NUM_FRA - 1);
  localparam logic [1:0]      FRQ_LAST = 2'(NUM_FRQ - 1);

  logic [1:0]        state_q, state_d;
  logic [1:0]        frq_q, frq_d;
  logic [2:0]        fra_q, fra_d;
  logic              hold_q, hold_d;
  logic              trig_q, trig_d;
  logic              seq_done_q, seq_done_d;
  logic              timeout_q, timeout_d;
  logic              adv_pend_q, adv_pend_d;
  logic [7:0]        frame_cnt_q, frame_cnt_d;
  logic [EXP_CW-1:0] exp_cnt_q, exp_cnt_d;
  logic              vsync_q;
  logic              vsync_rise;
  logic              rdy_rise;

  sync_rise u_rdy_sync (
    .clk    (clk),
    .rstn   (rstn),
    .d_i    (rdy),
    .rise_o (rdy_rise)
  );

  // Delay vsync by one clock for rising-edge detection
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) vsync_q <= 1'b0;
    else       vsync_q <= vsync;
  end

  assign vsync_rise = vsync & ~vsync_q;

  // Next-state logic; pass-through mode overrides every other event
  always_comb begin
    state_d     = state_q;
    frq_d       = frq_q;
    fra_d       = fra_q;
    hold_d      = hold_q;
    trig_d      = trig_q;
    seq_done_d  = 1'b0;
    timeout_d   = timeout_q;
    adv_pend_d  = adv_pend_q;
    frame_cnt_d = frame_cnt_q;
    exp_cnt_d   = exp_cnt_q;

    if (mode) begin
      state_d     = ST_IDLE;
      frq_d       = 2'd0;
      fra_d       = 3'd0;
      hold_d      = 1'b1;
      trig_d      = 1'b0;
      timeout_d   = 1'b0;
      adv_pend_d  = 1'b0;
      frame_cnt_d = 8'd0;
      exp_cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          adv_pend_d  = 1'b0;
          frame_cnt_d = 8'd0;
          state_d     = ST_WAIT_RDY;
        end

        ST_WAIT_RDY: begin
          // A ready seen in the same cycle as vsync counts as pending
          if (vsync_rise && (adv_pend_q || rdy_rise)) begin
            if (fra_q == FRA_LAST) begin
              fra_d      = 3'd0;
              frq_d      = (frq_q == FRQ_LAST) ? 2'd0 : frq_q + 2'd1;
              seq_done_d = (frq_q == FRQ_LAST);
            end else begin
              fra_d = fra_q + 3'd1;
            end
            hold_d      = 1'b0;
            adv_pend_d  = 1'b0;
            frame_cnt_d = 8'd0;
            state_d     = ST_ARM;
          end else begin
            if (rdy_rise) adv_pend_d = 1'b1;
            // Count frames spent waiting for the camera; saturate at 255
            if (vsync_rise && !adv_pend_q) begin
              if (frame_cnt_q != 8'hFF) frame_cnt_d = frame_cnt_q + 8'd1;
              if (frame_cnt_q + 8'd1 >= TIMEOUT_FRAMES) timeout_d = 1'b1;
            end
          end
        end

        ST_ARM: begin
          adv_pend_d = 1'b0;
          if (vsync_rise) begin
            trig_d    = 1'b1;
            hold_d    = 1'b1;
            exp_cnt_d = '0;
            state_d   = ST_EXPOSE;
          end
        end

        ST_EXPOSE: begin
          adv_pend_d = 1'b0;
          if (exp_cnt_q == EXP_LAST) begin
            trig_d      = 1'b0;
            frame_cnt_d = 8'd0;
            state_d     = ST_WAIT_RDY;
          end else begin
            exp_cnt_d = exp_cnt_q + EXP_CW'(1);
          end
        end

        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Sequencer state registers; reset drops trig asynchronously
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ST_IDLE;
      frq_q       <= 2'd0;
      fra_q       <= 3'd0;
      hold_q      <= 1'b1;
      trig_q      <= 1'b0;
      seq_done_q  <= 1'b0;
      timeout_q   <= 1'b0;
      adv_pend_q  <= 1'b0;
      frame_cnt_q <= 8'd0;
      exp_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      frq_q       <= frq_d;
      fra_q       <= fra_d;
      hold_q      <= hold_d;
      trig_q      <= trig_d;
      seq_done_q  <= seq_done_d;
      timeout_q   <= timeout_d;
      adv_pend_q  <= adv_pend_d;
      frame_cnt_q <= frame_cnt_d;
      exp_cnt_q   <= exp_cnt_d;
    end
  end

  assign frq         = frq_q;
  assign fra         = fra_q;
  assign hold        = hold_q;
  assign trig        = trig_q;
  assign seq_done    = seq_done_q;
  assign rdy_timeout = timeout_q;
  assign state_dbg   = state_q;
  assign f_frm       = (frq_q == 2'd0) && (fra_q == 3'd0);

endmodule : sli_seq_ctrl
`default_nettype wire

// File: tb/tb_sli_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_sli_seq_ctrl
// Description : Scoreboard bench for sli_seq_ctrl. Stimulus pushes expected
//               pattern steps; a negedge monitor checks every step and every
//               trigger pulse length.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sli_seq_ctrl;

  localparam int EXP      = 16;
  localparam int TMO      = 3;
  localparam int NUM_PATS = 24;

  logic       clk = 1'b0;
  logic       rstn, mode, vsync, rdy;
  logic [1:0] frq, state_dbg;
  logic [2:0] fra;
  logic       hold, trig, f_frm, seq_done, rdy_timeout;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int frq;
    int fra;
    int done;
  } step_t;

  step_t exp_q[$];
  int    ref_idx   = 0;
  bit    abort_ok  = 1'b0;
  int    trig_run  = 0;
  logic  prev_hold = 1'b1;

  sli_seq_ctrl #(
    .EXP_CYCLES     (EXP),
    .TIMEOUT_FRAMES (8'(TMO))
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .mode        (mode),
    .vsync       (vsync),
    .rdy         (rdy),
    .frq         (frq),
    .fra         (fra),
    .hold        (hold),
    .trig        (trig),
    .f_frm       (f_frm),
    .seq_done    (seq_done),
    .rdy_timeout (rdy_timeout),
    .state_dbg   (state_dbg)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d @%0t", name, act, req, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reference model: the pattern index walks 0..23 and wraps
  task automatic push_step();
    step_t s;
    ref_idx = (ref_idx + 1) % NUM_PATS;
    s.frq   = ref_idx / 8;
    s.fra   = ref_idx % 8;
    s.done  = (ref_idx == 0);
    exp_q.push_back(s);
  endtask

  // Ready pulse, then vsync 'gap' clocks after rdy rose (gap>=3 advances)
  task automatic adv_frame(input int gap);
    rdy = 1'b1;
    tick(2);
    rdy = 1'b0;
    tick(gap - 2);
    vsync = 1'b1;
    push_step();
    tick(2);
    vsync = 1'b0;
    tick(3);
  endtask

  // Vsync that starts the exposure; returns just after the edge that raised trig
  task automatic expose_start();
    vsync = 1'b1;
    tick(1);
    vsync = 1'b0;
  endtask

  task automatic full_frame(input int gap);
    adv_frame(gap);
    expose_start();
    tick(EXP + 4);
  endtask

  task automatic vs_pulse();
    vsync = 1'b1;
    tick(1);
    vsync = 1'b0;
    tick(3);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_state"}, 32'(state_dbg), 0);
    chk({tag, "_frq"},   32'(frq), 0);
    chk({tag, "_fra"},   32'(fra), 0);
    chk({tag, "_hold"},  32'(hold), 1);
    chk({tag, "_trig"},  32'(trig), 0);
    chk({tag, "_done"},  32'(seq_done), 0);
    chk({tag, "_tmo"},   32'(rdy_timeout), 0);
    chk({tag, "_ffrm"},  32'(f_frm), 1);
  endtask

  // Monitor: every hold fall is a pattern step; every trig pulse has fixed width
  always @(negedge clk) begin
    if (!rstn) begin
      trig_run = 0;
      abort_ok = 1'b0;
    end else begin
      if (prev_hold && !hold) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_step", 32'(fra), 32'hFFFF_FFFF);
        end else begin
          step_t e;
          e = exp_q.pop_front();
          chk("step_frq",  32'(frq), 32'(e.frq));
          chk("step_fra",  32'(fra), 32'(e.fra));
          chk("step_done", 32'(seq_done), 32'(e.done));
          chk("step_ffrm", 32'(f_frm), 32'(e.frq == 0 && e.fra == 0));
        end
      end else if (seq_done) begin
        chk("stray_seq_done", 32'(seq_done), 0);
      end
      if (trig) begin
        trig_run++;
      end else if (trig_run != 0) begin
        if (abort_ok) abort_ok = 1'b0;
        else          chk("trig_width", 32'(trig_run), 32'(EXP));
        trig_run = 0;
      end
    end
    prev_hold = hold;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn  = 1'b0;
    mode  = 1'b1;
    vsync = 1'b0;
    rdy   = 1'b0;
    tick(3);
    chk_reset_vals("rst");
    @(negedge clk) rstn = 1'b1;
    tick(2);
    mode = 1'b0;
    tick(2);
    chk("enter_wait", 32'(state_dbg), 1);

    // First step and exposure timing
    adv_frame(4);
    chk("first_fra",  32'(fra), 1);
    chk("first_hold", 32'(hold), 0);
    chk("first_arm",  32'(state_dbg), 2);
    chk("trig_pre",   32'(trig), 0);
    expose_start();
    chk("trig_start", 32'(trig), 1);
    chk("expose_st",  32'(state_dbg), 3);
    tick(EXP - 1);
    chk("trig_last",  32'(trig), 1);
    tick(1);
    chk("trig_end",   32'(trig), 0);
    chk("back_wait",  32'(state_dbg), 1);
    tick(3);

    // Ready during exposure is dropped
    adv_frame(5);
    expose_start();
    tick(3);
    rdy = 1'b1;
    tick(2);
    rdy = 1'b0;
    tick(EXP);
    vs_pulse();
    chk("drop_state", 32'(state_dbg), 1);
    chk("drop_fra",   32'(fra), 32'(ref_idx % 8));
    chk("drop_hold",  32'(hold), 1);

    // Random gaps, enough steps for a full wrap (same-cycle ready at gap 3)
    for (int i = 0; i < NUM_PATS + 2; i++) begin
      full_frame(int'($urandom_range(3, 9)));
      tick(int'($urandom_range(0, 5)));
    end
    chk("no_timeout", 32'(rdy_timeout), 0);

    // Ready timeout and its clearing by pass-through mode
    mode = 1'b1;
    tick(1);
    mode = 1'b0;
    ref_idx = 0;
    tick(2);
    vs_pulse();
    vs_pulse();
    chk("tmo_before", 32'(rdy_timeout), 0);
    vs_pulse();
    chk("tmo_set",    32'(rdy_timeout), 1);
    tick(10);
    chk("tmo_held",   32'(rdy_timeout), 1);
    mode = 1'b1;
    tick(1);
    chk("tmo_clear",  32'(rdy_timeout), 0);
    chk("tmo_idle",   32'(state_dbg), 0);
    mode = 1'b0;
    tick(2);

    // Pass-through mode aborts an exposure at counter 5
    adv_frame(4);
    expose_start();
    tick(5);
    abort_ok = 1'b1;
    mode = 1'b1;
    tick(1);
    chk("abort_trig",  32'(trig), 0);
    chk("abort_state", 32'(state_dbg), 0);
    chk("abort_frq",   32'(frq), 0);
    chk("abort_fra",   32'(fra), 0);
    chk("abort_hold",  32'(hold), 1);
    mode = 1'b0;
    ref_idx = 0;
    tick(3);

    // Asynchronous reset in the middle of an exposure
    adv_frame(6);
    expose_start();
    tick(4);
    #2 rstn = 1'b0;
    #1 chk("async_trig", 32'(trig), 0);
    ref_idx = 0;
    tick(2);
    @(negedge clk) rstn = 1'b1;
    #1 chk_reset_vals("rel");
    tick(3);
    full_frame(5);
    chk("post_rst_fra", 32'(fra), 1);

    chk("queue_empty", 32'(exp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_sli_seq_ctrl
`default_nettype wire

// File: doc/sli_seq_ctrl.md
SLI_SEQ_CTRL -- requirements
Module: sli_seq_ctrl

Interface
REQ-001 SHALL have parameter EXP_CYCLES, default 20'h80000, trigger high time in clk cycles (≥2).
REQ-002 SHALL have parameter TIMEOUT_FRAMES, default 8'd240, vsync edges allowed in WAIT_RDY before timeout (≥1).
REQ-003 SHALL have port clk  in  1  pixel clock; sole clock.
REQ-004 SHALL have port rstn  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port mode  in  1  1 = pass-through (sequencer parked), 0 = pattern generation; synchronous to clk.
REQ-006 SHALL have port vsync  in  1  frame sync level, synchronous to clk.
REQ-007 SHALL have port rdy  in  1  camera-ready, asynchronous.
REQ-008 SHALL have port frq  out  2  spatial-frequency index, 0..2.
REQ-009 SHALL have port fra  out  3  phase-frame index, 0..7.
REQ-010 SHALL have port hold  out  1  1 = current pattern is a repeat, not a fresh frame.
REQ-011 SHALL have port trig  out  1  camera exposure trigger.
REQ-012 SHALL have port f_frm  out  1  high when frq==0 and fra==0.
REQ-013 SHALL have port seq_done  out  1  one-cycle pulse on frq/fra wrap 2/7 -> 0/0.
REQ-014 SHALL have port rdy_timeout  out  1  sticky timeout flag.
REQ-015 SHALL have port state_dbg  out  2  current FSM state encoding.

Function
REQ-016 vsync_rise SHALL be vsync & ~vsync_q, where vsync_q is vsync registered once.
REQ-017 rdy SHALL pass a 2-flop synchronizer plus rise detector; rdy_rise is asserted 3 cycles after an rdy 0->1 edge.
REQ-018 FSM states SHALL be IDLE=0, WAIT_RDY=1, ARM=2, EXPOSE=3.
REQ-019 IDLE: frq=0, fra=0, hold=1, trig=0; mode==0 -> WAIT_RDY next cycle.
REQ-020 WAIT_RDY: rdy_rise sets adv_pend; on vsync_rise with adv_pend set (or rdy_rise in the same cycle), indices advance, hold<=0, adv_pend<=0, -> ARM.
REQ-021 Advance: fra<=fra+1; when fra==7, fra<=0 and frq<=(frq==2)?0:frq+1; seq_done pulses in the same cycle as frq/fra update to 0/0.
REQ-022 ARM: the next vsync_rise -> EXPOSE, trig<=1, exposure counter<=0, hold<=1.
REQ-023 EXPOSE: counter increments each cycle; when counter==EXP_CYCLES-1, trig<=0 -> WAIT_RDY, so trig is high exactly EXP_CYCLES cycles.
REQ-024 rdy_rise in ARM or EXPOSE SHALL be discarded; adv_pend SHALL clear on entry to WAIT_RDY.
REQ-025 In WAIT_RDY without adv_pend, each vsync_rise SHALL increment an 8-bit frame counter; reaching TIMEOUT_FRAMES sets rdy_timeout; the counter clears on leaving WAIT_RDY.
REQ-026 rdy_timeout SHALL clear only on reset or mode==1.
REQ-027 mode==1 in any state SHALL force IDLE next cycle, trig<=0, frq/fra<=0, hold<=1, adv_pend<=0, and the counters cleared; this takes priority over all other events.
REQ-028 frq SHALL never take value 3.
REQ-029 f_frm SHALL be combinational from the registered frq/fra.
REQ-030 All outputs except f_frm SHALL be registered.

Reset
REQ-031 On rstn low: state=IDLE, frq=0, fra=0, hold=1, trig=0, seq_done=0, rdy_timeout=0, adv_pend=0, counters=0, and the synchronizer and vsync_q flops=0.
REQ-032 Reset assertion mid-EXPOSE SHALL drop trig immediately (asynchronously).
REQ-033 Reset release SHALL be followed by normal operation from IDLE with no spurious rdy_rise.

Structure
REQ-034 Package sli_pkg SHALL hold the state encoding, NUM_FRA=8, NUM_FRQ=3, and default EXP_CYCLES/TIMEOUT_FRAMES.
REQ-035 A single sub-module sync_rise SHALL implement the 2-flop synchronizer plus rise detector, with async active-low reset.

Verification
REQ-036 EXP_CYCLES=16, mode=0, rdy pulse, then two vsync edges -> fra 0->1 at the first vsync_rise, hold=0 for one frame, trig high exactly 16 cycles starting the cycle after the second vsync_rise.
REQ-037 24 rdy/vsync cycles -> fra wraps 7->0 with frq 0->1->2->0; seq_done pulses once at the 24th advance, with f_frm=1 at that point.
REQ-038 rdy pulsed during EXPOSE -> no advance, adv_pend=0 on return to WAIT_RDY.
REQ-039 TIMEOUT_FRAMES=3, no rdy, 3 vsync edges -> rdy_timeout=1 and held; mode=1 pulse clears it.
REQ-040 mode=1 at EXPOSE counter=5 -> trig=0 and state IDLE next cycle, frq=fra=0, hold=1.
REQ-041 rstn low mid-EXPOSE -> trig=0 without a clock edge; after release, the state is IDLE and all outputs are at their REQ-031 values.
